// File: rtl/paddsb_accum_seq_if.sv
// ---------------------------------------------------------------------------
// paddsb_accum_seq_if
//
// Groups the command, status, memory-read and adder-operand signals of the
// packed saturating accumulate sequencer into one bundle.
//
//   Command : start, base_addr, count          (environment -> sequencer)
//   Status  : busy, done, result, sat, err     (sequencer -> environment)
//   Memory  : mem_rd_en, mem_addr              (sequencer -> memory)
//             mem_rdy, mem_data                (memory -> sequencer)
//   Adder   : add_a, add_b                     (sequencer -> shared adder)
//             add_sum                          (shared adder -> sequencer)
//
// Modports:
//   master : the sequencer's view (drives status, memory request, operands)
//   slave  : the environment's view (command source, memory, shared adder)
// ---------------------------------------------------------------------------
interface paddsb_accum_seq_if #(
    parameter int unsigned COUNT_W = 8
);
    // Command
    logic               start;
    logic [15:0]        base_addr;
    logic [COUNT_W-1:0] count;

    // Status
    logic               busy;
    logic               done;
    logic [15:0]        result;
    logic [3:0]         sat;
    logic               err;

    // Memory read port
    logic               mem_rd_en;
    logic [15:0]        mem_addr;
    logic               mem_rdy;
    logic [15:0]        mem_data;

    // Shared packed saturating adder
    logic [15:0]        add_a;
    logic [15:0]        add_b;
    logic [15:0]        add_sum;

    modport master (
        input  start, base_addr, count,
        input  mem_rdy, mem_data,
        input  add_sum,
        output busy, done, result, sat, err,
        output mem_rd_en, mem_addr,
        output add_a, add_b
    );

    modport slave (
        output start, base_addr, count,
        output mem_rdy, mem_data,
        output add_sum,
        input  busy, done, result, sat, err,
        input  mem_rd_en, mem_addr,
        input  add_a, add_b
    );
endinterface

// File: rtl/paddsb_accum_seq.sv
// ---------------------------------------------------------------------------
// paddsb_accum_seq
//
// Sums a vector of packed 4x4-bit signed words held in memory, using the
// shared packed saturating adder that lives outside this block. On an
// accepted start the sequencer reads COUNT words from BASE (stepping by
// ADDR_STEP bytes), presents each word together with the running
// accumulator to the adder for exactly one cycle, and takes the adder's sum
// as the new accumulator. Per-lane overflow is detected locally and kept as
// sticky flags. A read that stays unacknowledged for TIMEOUT cycles aborts
// the command with err set; the partial sum is still reported.
//
// Ports:
//   clk     : clock, all state on the rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : paddsb_accum_seq_if.master
//             start/base_addr/count  command (sampled only when idle)
//             busy                   high in REQ/ACC/DONE
//             done                   one-cycle pulse, result valid with it
//             result/sat/err         held until overwritten by a new command
//             mem_rd_en/mem_addr     read request, high for all of REQ
//             mem_rdy/mem_data       read acknowledge with same-cycle data
//             add_a/add_b            adder operands, zero outside ACC
//             add_sum                combinational adder result
//
// Parameters:
//   COUNT_W   : width of count (max vector length 2^COUNT_W-1)
//   ADDR_STEP : byte address increment per word
//   TIMEOUT   : max REQ cycles without mem_rdy before abort (>= 1)
// ---------------------------------------------------------------------------
module paddsb_accum_seq #(
    parameter int unsigned COUNT_W   = 8,
    parameter int unsigned ADDR_STEP = 2,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    paddsb_accum_seq_if.master bus
);

    // The wait counter only ever holds 0 .. TIMEOUT-1.
    localparam int unsigned         WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [15:0]         STEP      = 16'(ADDR_STEP);
    localparam logic [COUNT_W-1:0]  ONE_LEFT  = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [15:0]        cur_addr_q,  cur_addr_d;   // address of the word being fetched
    logic [15:0]        mem_addr_q,  mem_addr_d;   // only reloaded on entry to REQ
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [15:0]        acc_q,       acc_d;
    logic [15:0]        word_q,      word_d;
    logic [15:0]        result_q,    result_d;
    logic [3:0]         sat_q,       sat_d;
    logic               err_q,       err_d;

    logic [15:0]        next_addr;
    logic [3:0]         sat_hit;

    // Address arithmetic wraps naturally at 16 bits (0xFFFE -> 0x0000).
    assign next_addr = cur_addr_q + STEP;

    // -----------------------------------------------------------------------
    // Lane overflow detection. Each nibble is sign-extended to 5 bits; the
    // true sum lies outside [-8,7] exactly when the top two bits differ.
    // Evaluated every cycle but only folded into sat_q during ACC, when
    // acc_q/word_q are the operands the adder is seeing.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [4:0] lane_sum;
        assign lane_sum   = {acc_q[4*i+3],  acc_q[4*i +: 4]}
                          + {word_q[4*i+3], word_q[4*i +: 4]};
        assign sat_hit[i] = lane_sum[4] ^ lane_sum[3];
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d takes its current value first, so each path below
        // only overrides what changes and no latch can be inferred.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        acc_d       = acc_q;
        word_d      = word_q;
        result_d    = result_q;
        sat_d       = sat_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cur_addr_d  = bus.base_addr;
                    remaining_d = bus.count;
                    wait_cnt_d  = '0;
                    acc_d       = '0;
                    sat_d       = '0;
                    err_d       = 1'b0;
                    if (bus.count == '0) begin
                        // Empty vector: report the zero sum straight away.
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        mem_addr_d = bus.base_addr;
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (bus.mem_rdy) begin
                    word_d     = bus.mem_data;
                    wait_cnt_d = '0;
                    state_d    = ST_ACC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // This is the TIMEOUT-th unacknowledged cycle: abort and
                    // report whatever has been accumulated so far.
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                    result_d   = acc_q;
                    state_d    = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_ACC: begin
                acc_d       = bus.add_sum;
                sat_d       = sat_q | sat_hit;
                cur_addr_d  = next_addr;
                remaining_d = remaining_q - ONE_LEFT;
                if (remaining_q == ONE_LEFT) begin
                    // Load result on the way into DONE so it is already
                    // valid while the done pulse is high.
                    result_d = bus.add_sum;
                    state_d  = ST_DONE;
                end else begin
                    mem_addr_d = next_addr;
                    state_d    = ST_REQ;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            result_q    <= '0;
            sat_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            acc_q       <= acc_d;
            word_q      <= word_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Control strobes decode straight from the state register, so
    // they drop the moment reset is asserted.
    // -----------------------------------------------------------------------
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.mem_rd_en = (state_q == ST_REQ);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.add_a     = (state_q == ST_ACC) ? acc_q  : '0;
    assign bus.add_b     = (state_q == ST_ACC) ? word_q : '0;
    assign bus.result    = result_q;
    assign bus.sat       = sat_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_paddsb_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_paddsb_accum_seq
//
// Bench for paddsb_accum_seq. Plays the environment: command source, a
// memory whose acknowledge timing is scheduled per word, and the shared
// packed saturating adder. For every command a list of expected per-cycle
// observations is built from the behaviour rules (fetch/accumulate cadence,
// stalls, timeout, saturating lane arithmetic) and compared against the DUT
// on each falling edge.
// ---------------------------------------------------------------------------
module tb_paddsb_accum_seq;

    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    paddsb_accum_seq_if #(.COUNT_W(8)) bus ();

    paddsb_accum_seq #(
        .COUNT_W  (8),
        .ADDR_STEP(2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic int nib(input logic [3:0] v);
        int x;
        x = int'(v);
        if (x > 7) x -= 16;
        return x;
    endfunction

    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        int z;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            z = nib(a[4*i +: 4]) + nib(b[4*i +: 4]);
            if (z > 7)  z = 7;
            if (z < -8) z = -8;
            s[4*i +: 4] = 4'(z);
        end
        return s;
    endfunction

    function automatic logic [3:0] model_ov(input logic [15:0] a, input logic [15:0] b);
        logic [3:0] ov;
        int z;
        ov = '0;
        for (int i = 0; i < 4; i++) begin
            z = nib(a[4*i +: 4]) + nib(b[4*i +: 4]);
            ov[i] = (z > 7) || (z < -8);
        end
        return ov;
    endfunction

    // The shared adder sitting outside the DUT.
    assign bus.add_sum = model_sum(bus.add_a, bus.add_b);

    // ---------------- expected-cycle records ----------------
    typedef struct {
        bit          done;
        bit          rd_en;
        logic [15:0] addr;
        bit          rdy;    // what the memory answers this cycle
        logic [15:0] data;
        logic [15:0] add_a;
        logic [15:0] add_b;
    } cyc_t;

    function automatic cyc_t mk(input bit d, input bit rd, input logic [15:0] ad,
                                input bit ry, input logic [15:0] dt,
                                input logic [15:0] aa, input logic [15:0] ab);
        cyc_t c;
        c.done = d; c.rd_en = rd; c.addr = ad; c.rdy = ry;
        c.data = dt; c.add_a = aa; c.add_b = ab;
        return c;
    endfunction

    logic [15:0] words [32];
    int          stalls[32];
    logic [15:0] last_addr;
    logic [15:0] held_result;
    logic [3:0]  held_sat;
    logic        held_err;
    int          done_off;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle();
        check("idle_busy",     32'(bus.busy),      0);
        check("idle_done",     32'(bus.done),      0);
        check("idle_rd_en",    32'(bus.mem_rd_en), 0);
        check("idle_add_a",    32'(bus.add_a),     0);
        check("idle_add_b",    32'(bus.add_b),     0);
        check("idle_mem_addr", 32'(bus.mem_addr),  32'(last_addr));
        check("idle_result",   32'(bus.result),    32'(held_result));
        check("idle_sat",      32'(bus.sat),       32'(held_sat));
        check("idle_err",      32'(bus.err),       32'(held_err));
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(negedge clk);
            check_idle();
            bus.start    = 1'b0;
            bus.mem_rdy  = 1'($urandom_range(0, 1));
            bus.mem_data = 16'($urandom);
        end
    endtask

    task automatic clear_stalls();
        for (int k = 0; k < 32; k++) stalls[k] = 0;
    endtask

    task automatic do_abort();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mem_rdy = 1'b0;
        #1;
        check("rst_busy",     32'(bus.busy),      0);
        check("rst_done",     32'(bus.done),      0);
        check("rst_rd_en",    32'(bus.mem_rd_en), 0);
        check("rst_mem_addr", 32'(bus.mem_addr),  0);
        check("rst_add_a",    32'(bus.add_a),     0);
        check("rst_add_b",    32'(bus.add_b),     0);
        check("rst_result",   32'(bus.result),    0);
        check("rst_sat",      32'(bus.sat),       0);
        check("rst_err",      32'(bus.err),       0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_done", 32'(bus.done), 0);
        end
        rst_n       = 1'b1;
        last_addr   = '0;
        held_result = '0;
        held_sat    = '0;
        held_err    = 1'b0;
    endtask

    // noise: 0 = start only in the start cycle, 1 = random start pulses with
    // junk base/count while busy, 2 = start held high with the same command.
    // to_word >= 0 makes the memory never answer that word (timeout).
    // abort_at > 0 asserts reset in that cycle after the start.
    task automatic run_cmd(input logic [15:0] base, input int n, input int to_word,
                           input int noise, input int abort_at);
        cyc_t        q[$];
        logic [15:0] acc, a, la;
        logic [3:0]  satv;
        int          k_end;

        acc   = '0;
        satv  = '0;
        la    = last_addr;
        k_end = (to_word >= 0) ? to_word : n;
        for (int k = 0; k < k_end; k++) begin
            a  = base + 16'(2 * k);
            la = a;
            for (int s = 0; s < stalls[k]; s++)
                q.push_back(mk(1'b0, 1'b1, a, 1'b0, 16'h0, 16'h0, 16'h0));
            q.push_back(mk(1'b0, 1'b1, a, 1'b1, words[k], 16'h0, 16'h0));
            q.push_back(mk(1'b0, 1'b0, a, 1'b0, 16'h0, acc, words[k]));
            satv = satv | model_ov(acc, words[k]);
            acc  = model_sum(acc, words[k]);
        end
        if (to_word >= 0) begin
            a  = base + 16'(2 * to_word);
            la = a;
            repeat (TIMEOUT) q.push_back(mk(1'b0, 1'b1, a, 1'b0, 16'h0, 16'h0, 16'h0));
        end
        q.push_back(mk(1'b1, 1'b0, la, 1'b0, 16'h0, 16'h0, 16'h0));

        @(negedge clk);
        check_idle();
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = 8'(n);
        bus.mem_rdy   = 1'($urandom_range(0, 1));
        bus.mem_data  = 16'($urandom);
        done_off      = -1;

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i + 1 == abort_at) begin
                do_abort();
                return;
            end
            check("busy",     32'(bus.busy),      1);
            check("done",     32'(bus.done),      32'(q[i].done));
            check("rd_en",    32'(bus.mem_rd_en), 32'(q[i].rd_en));
            check("mem_addr", 32'(bus.mem_addr),  32'(q[i].addr));
            check("add_a",    32'(bus.add_a),     32'(q[i].add_a));
            check("add_b",    32'(bus.add_b),     32'(q[i].add_b));
            if (bus.done === 1'b1 && done_off < 0) done_off = i + 1;
            if (q[i].done) begin
                check("result", 32'(bus.result), 32'(acc));
                check("sat",    32'(bus.sat),    32'(satv));
                check("err",    32'(bus.err),    (to_word >= 0) ? 1 : 0);
                held_result = acc;
                held_sat    = satv;
                held_err    = (to_word >= 0);
            end else begin
                check("err_busy", 32'(bus.err), 0);
            end

            if (noise == 1) begin
                bus.start     = ($urandom_range(0, 2) == 0);
                bus.base_addr = 16'($urandom);
                bus.count     = 8'($urandom);
            end else if (noise == 0) begin
                bus.start = 1'b0;
            end
            if (q[i].rd_en) begin
                bus.mem_rdy  = q[i].rdy;
                bus.mem_data = q[i].rdy ? q[i].data : 16'($urandom);
            end else begin
                bus.mem_rdy  = 1'($urandom_range(0, 1));
                bus.mem_data = 16'($urandom);
            end
        end
        last_addr = la;
    endtask

    task automatic rand_cmd();
        int n, to;
        n  = $urandom_range(0, 7);
        to = -1;
        for (int k = 0; k < n; k++) begin
            words[k]  = 16'($urandom);
            stalls[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
        if (n > 0 && $urandom_range(0, 7) == 0) to = $urandom_range(0, n - 1);
        run_cmd(($urandom_range(0, 3) == 0) ? 16'hFFFA : 16'($urandom & 32'hFFFE),
                n, to, $urandom_range(0, 1), 0);
    endtask

    // Global time bound so a wedged run still ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        bus.mem_rdy   = 1'b0;
        bus.mem_data  = '0;
        last_addr     = '0;
        held_result   = '0;
        held_sat      = '0;
        held_err      = 1'b0;
        clear_stalls();

        // Reset values
        repeat (2) @(negedge clk);
        check_idle();
        rst_n = 1'b1;
        idle_gap(1);

        // Empty vector
        run_cmd(16'h0040, 0, -1, 0, 0);
        check("t1_done_cycle", 32'(done_off),   1);
        check("t1_result",     32'(bus.result), 32'h0000);
        idle_gap(1);

        // Three plain words
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h1111;
        run_cmd(16'h0100, 3, -1, 0, 0);
        check("t2_done_cycle", 32'(done_off),   7);
        check("t2_result",     32'(bus.result), 32'h4444);
        check("t2_sat",        32'(bus.sat),    32'h0);
        idle_gap(2);

        // Saturation cases
        words[0] = 16'h7777; words[1] = 16'h1111;
        run_cmd(16'h0200, 2, -1, 0, 0);
        check("t3a_result", 32'(bus.result), 32'h7777);
        check("t3a_sat",    32'(bus.sat),    32'hF);
        words[0] = 16'h8888; words[1] = 16'hFFFF;
        run_cmd(16'h0300, 2, -1, 0, 0);
        check("t3b_result", 32'(bus.result), 32'h8888);
        check("t3b_sat",    32'(bus.sat),    32'hF);
        words[0] = 16'h7F00; words[1] = 16'h1100;
        run_cmd(16'h0400, 2, -1, 0, 0);
        check("t3c_result", 32'(bus.result), 32'h7000);
        check("t3c_sat",    32'(bus.sat),    32'h8);
        idle_gap(1);

        // Address wrap
        words[0] = 16'h0123; words[1] = 16'h0321;
        run_cmd(16'hFFFE, 2, -1, 0, 0);
        check("t4_done_cycle", 32'(done_off),     5);
        check("t4_last_addr",  32'(bus.mem_addr), 32'h0000);
        idle_gap(1);

        // Timeout on the second word, then a clean command clears err
        words[0] = 16'h1234;
        run_cmd(16'h0500, 3, 1, 0, 0);
        check("t5_done_cycle", 32'(done_off),   18);
        check("t5_result",     32'(bus.result), 32'h1234);
        check("t5_err",        32'(bus.err),    1);
        idle_gap(1);
        words[0] = 16'h0001;
        run_cmd(16'h0600, 1, -1, 0, 0);
        check("t5b_err",    32'(bus.err),    0);
        check("t5b_result", 32'(bus.result), 32'h0001);

        // Start pulses while busy, with stalls
        words[0] = 16'h3210; words[1] = 16'h4567; words[2] = 16'hC0DE; words[3] = 16'h0F0F;
        stalls[1] = 2; stalls[3] = 1;
        run_cmd(16'h0700, 4, -1, 1, 0);
        clear_stalls();
        // Reset during ACC of the second word, then a fresh command
        run_cmd(16'h0800, 3, -1, 0, 4);
        words[0] = 16'h2121; words[1] = 16'h1212;
        run_cmd(16'h0900, 2, -1, 0, 0);
        check("t6_result", 32'(bus.result), 32'h3333);

        // Start held high re-triggers right after DONE
        words[0] = 16'h0005;
        run_cmd(16'h0A00, 1, -1, 2, 0);
        run_cmd(16'h0A00, 1, -1, 0, 0);
        check("retrig_done_cycle", 32'(done_off), 3);
        idle_gap(1);

        // Longer vector
        for (int k = 0; k < 20; k++) begin
            words[k]  = 16'($urandom);
            stalls[k] = k % 3;
        end
        run_cmd(16'hFFF0, 20, -1, 1, 0);
        clear_stalls();

        // Randomized commands
        for (int c = 0; c < 60; c++) begin
            rand_cmd();
            idle_gap($urandom_range(0, 2));
        end
        idle_gap(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
